// File: rtl/sonic_circbuf_sched.sv
// sonic_circbuf_sched: write/read pointer tracking and BLOCK-sized DMA scheduling for one SONIC ring.
// Define SONIC_CIRCBUF_STATS_EN to add the blk_cnt and drop_cnt statistics outputs.
module sonic_circbuf_sched #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 15872,
    parameter int BLOCK  = 256
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              ena,
    input  logic              wr_incr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_full,
    input  logic              ovf_clr,
    output logic              overflow,
    output logic              dma_req,
    output logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_ack,
    input  logic              dma_done,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   level
`ifdef SONIC_CIRCBUF_STATS_EN
    ,
    output logic [31:0]       blk_cnt,
    output logic [15:0]       drop_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    localparam logic [ADDR_W:0]   DEP  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   BLK  = (ADDR_W+1)'(BLOCK);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, dma_addr_q;
    logic [ADDR_W:0]   level_q, level_d, rd_next;
    logic              ovf_q, ovf_d, dma_req_q, done_w, acc_w, drop_w;

    // A completion frees a block in the same cycle, so a write at full is accepted then.
    assign wr_full  = level_q == DEP;
    assign done_w   = state_q == WAIT && dma_done;
    assign acc_w    = wr_incr && ena && (!wr_full || done_w);
    assign drop_w   = wr_incr && ena && wr_full && !done_w;
    assign wr_addr  = wr_addr_q;
    assign rd_addr  = rd_addr_q;
    assign level    = level_q;
    assign overflow = ovf_q;
    assign dma_req  = dma_req_q;
    assign dma_addr = dma_addr_q;

    always_comb begin
        wr_addr_d = !acc_w ? wr_addr_q : (wr_addr_q == LAST ? '0 : wr_addr_q + ADDR_W'(1));
        level_d   = level_q + (ADDR_W+1)'(acc_w) - (done_w ? BLK : '0);
        ovf_d     = drop_w || (ovf_q && !ovf_clr);
        rd_next   = {1'b0, rd_addr_q} + BLK;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            wr_addr_q <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wr_addr_q <= wr_addr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            dma_req_q  <= 1'b0;
            dma_addr_q <= '0;
            rd_addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (ena && level_q >= BLK) begin
                    state_q    <= REQ;
                    dma_req_q  <= 1'b1;
                    dma_addr_q <= rd_addr_q;
                end
                REQ: if (dma_ack) begin
                    state_q   <= WAIT;
                    dma_req_q <= 1'b0;
                end
                WAIT: if (dma_done) begin
                    state_q   <= IDLE;
                    rd_addr_q <= rd_next == DEP ? '0 : rd_next[ADDR_W-1:0];
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SONIC_CIRCBUF_STATS_EN
    logic [31:0] blk_q;
    logic [15:0] drop_q, drop_base;

    assign blk_cnt   = blk_q;
    assign drop_cnt  = drop_q;
    assign drop_base = ovf_clr ? '0 : drop_q;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            blk_q  <= '0;
            drop_q <= '0;
        end else begin
            blk_q  <= blk_q + 32'(done_w);
            drop_q <= drop_w && drop_base != 16'hFFFF ? drop_base + 16'd1 : drop_base;
        end
    end
`endif
endmodule

// File: tb/tb_sonic_circbuf_sched.sv
// tb_sonic_circbuf_sched: vector table, directed corner sequences and random traffic
// checked against an integer-arithmetic model of the ring scheduler.
module tb_sonic_circbuf_sched;
    localparam int AW = 14, DEPTH = 15872, BLOCK = 256;

    logic clk_in = 0, reset_n = 0, ena = 0, wr_incr = 0, ovf_clr = 0, dma_ack = 0, dma_done = 0;
    logic [AW-1:0] wr_addr, dma_addr, rd_addr;
    logic [AW:0]   level;
    logic          wr_full, overflow, dma_req;
`ifdef SONIC_CIRCBUF_STATS_EN
    logic [31:0] blk_cnt;
    logic [15:0] drop_cnt;
    int          m_blk, m_drop;
`endif

    int total = 0, bad = 0;
    int m_wr, m_rd, m_lvl, m_addr;
    bit m_ovf, m_req, m_fly;

    typedef struct {bit e, w, a, d, c; int lvl, wa; bit req, ovf;} vec_t;
    vec_t tbl[6];

    sonic_circbuf_sched dut (
        .clk_in(clk_in), .reset_n(reset_n), .ena(ena), .wr_incr(wr_incr),
        .wr_addr(wr_addr), .wr_full(wr_full), .ovf_clr(ovf_clr), .overflow(overflow),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_done(dma_done),
        .rd_addr(rd_addr), .level(level)
`ifdef SONIC_CIRCBUF_STATS_EN
        , .blk_cnt(blk_cnt), .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_lvl = 0; m_addr = 0; m_ovf = 0; m_req = 0; m_fly = 0;
`ifdef SONIC_CIRCBUF_STATS_EN
        m_blk = 0; m_drop = 0;
`endif
    endtask

    task automatic cmp_model();
        chk("m_wr_addr", wr_addr, m_wr);
        chk("m_rd_addr", rd_addr, m_rd);
        chk("m_level", level, m_lvl);
        chk("m_wr_full", wr_full, m_lvl == DEPTH);
        chk("m_overflow", overflow, m_ovf);
        chk("m_dma_req", dma_req, m_req);
        chk("m_dma_addr", dma_addr, m_addr);
`ifdef SONIC_CIRCBUF_STATS_EN
        chk("m_blk_cnt", blk_cnt, m_blk);
        chk("m_drop_cnt", drop_cnt, m_drop);
`endif
    endtask

    // One clock: the model predicts from its own state and the applied inputs.
    task automatic tick(input bit e, input bit w, input bit a, input bit d, input bit c);
        bit full, dn, acc, drp;
        ena = e; wr_incr = w; dma_ack = a; dma_done = d; ovf_clr = c;
        full = m_lvl == DEPTH;
        dn   = m_fly && d;
        acc  = w && e && (!full || dn);
        drp  = w && e && full && !dn;
        if (dn) begin
            m_rd = (m_rd + BLOCK) % DEPTH; m_fly = 0;
        end else if (m_req && a) begin
            m_req = 0; m_fly = 1;
        end else if (!m_req && !m_fly && e && m_lvl >= BLOCK) begin
            m_req = 1; m_addr = m_rd;
        end
        m_lvl = m_lvl + int'(acc) - (dn ? BLOCK : 0);
        m_wr  = (m_wr + int'(acc)) % DEPTH;
        m_ovf = drp || (m_ovf && !c);
`ifdef SONIC_CIRCBUF_STATS_EN
        if (dn) m_blk++;
        if (c) m_drop = 0;
        if (drp && m_drop < 65535) m_drop++;
`endif
        @(posedge clk_in); #1;
        cmp_model();
    endtask

    task automatic do_reset();
        reset_n = 0; model_reset();
        ena = 0; wr_incr = 0; dma_ack = 0; dma_done = 0; ovf_clr = 0;
        #1;
        chk("rst_req", dma_req, 0);
        chk("rst_level", level, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_dma_addr", dma_addr, 0);
        chk("rst_ovf", overflow, 0);
        #3 reset_n = 1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!dma_req && n < 20) begin
            tick(1, 0, 0, 0, 0);
            n++;
        end
        chk("req_wait", dma_req, 1);
    endtask

    task automatic do_block();
        wait_req();
        tick(1, 0, 1, 0, 0);
        tick(1, 0, 0, 1, 0);
    endtask

    initial begin
        tbl[0] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 1, 0, 0, 1, 1, 0, 0};
        tbl[2] = '{1, 1, 0, 1, 0, 2, 2, 0, 0};
        tbl[3] = '{1, 0, 0, 0, 1, 2, 2, 0, 0};
        tbl[4] = '{0, 1, 0, 0, 0, 2, 2, 0, 0};
        tbl[5] = '{1, 1, 0, 0, 0, 3, 3, 0, 0};
        #2;
        do_reset();
        @(posedge clk_in); #1;
        foreach (tbl[i]) begin
            tick(tbl[i].e, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].c);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
            chk($sformatf("tbl%0d_wr_addr", i), wr_addr, tbl[i].wa);
            chk($sformatf("tbl%0d_req", i), dma_req, tbl[i].req);
            chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].ovf);
        end
        // First request threshold
        for (int i = 3; i < 255; i++) tick(1, 1, 0, 0, 0);
        chk("lvl255", level, 255);
        chk("wa255", wr_addr, 'h0FF);
        chk("req_at255", dma_req, 0);
        tick(1, 1, 0, 0, 0);
        chk("req_same_cycle256", dma_req, 0);
        tick(1, 0, 0, 0, 0);
        chk("req_after256", dma_req, 1);
        chk("first_dma_addr", dma_addr, 0);
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0);
        chk("req_held", dma_req, 1);
        tick(1, 0, 1, 0, 0);
        chk("req_drop_after_ack", dma_req, 0);
        tick(1, 0, 0, 1, 0);
        chk("rd_after_done", rd_addr, 'h100);
        chk("lvl_after_done", level, 0);
        tick(1, 0, 0, 0, 0);
        chk("idle_no_req", dma_req, 0);
        // Fill to full, then drop two writes
        do_reset();
        for (int i = 0; i < DEPTH; i++) tick(1, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        chk("full_flag", wr_full, 1);
        chk("full_wr_addr", wr_addr, 0);
        chk("full_ovf", overflow, 1);
        chk("full_level", level, 'h3E00);
`ifdef SONIC_CIRCBUF_STATS_EN
        chk("drop_cnt2", drop_cnt, 2);
`endif
        // Write coinciding with completion at full
        tick(1, 0, 1, 0, 0);
        tick(1, 1, 0, 1, 0);
        chk("full_done_level", level, 'h3D01);
        chk("full_done_wr_addr", wr_addr, 1);
        chk("ovf_sticky", overflow, 1);
        tick(1, 0, 0, 0, 1);
        chk("ovf_cleared", overflow, 0);
        // Walk read pointer to the wrap point
        for (int i = 0; i < 60; i++) do_block();
        chk("rd_3d00", rd_addr, 'h3D00);
        do_block();
        chk("rd_wrap", rd_addr, 0);
        chk("lvl_after_wrap", level, 1);
        for (int i = 0; i < 255; i++) tick(1, 1, 0, 0, 0);
        wait_req();
        chk("wrap_dma_addr", dma_addr, 0);
        // Asynchronous reset mid-request
        reset_n = 0; model_reset();
        #1;
        chk("async_req", dma_req, 0);
        chk("async_level", level, 0);
        chk("async_rd", rd_addr, 0);
        chk("async_wr", wr_addr, 0);
        #3 reset_n = 1;
        tick(1, 0, 1, 0, 0);
        chk("ack_ignored_req", dma_req, 0);
        chk("ack_ignored_lvl", level, 0);
        // Random traffic
        for (int i = 0; i < 4000; i++)
            tick($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sonic_circbuf_sched.md
Name: sonic_circbuf_sched

Overview:
- Pointer and DMA scheduler for one SONIC circular buffer of DEPTH entries (0x3E00 default).
- Producer side (RX datapath) advances the write pointer one entry at a time.
- Scheduler tracks fill level and hands fixed BLOCK-sized chunks to the host DMA engine over a req/ack/done handshake.
- Read pointer advances only on DMA completion; addresses wrap at DEPTH-1.

Parameters:
- ADDR_W, 14: pointer width.
- DEPTH, 15872 (0x3E00): ring entries. Must be a multiple of BLOCK and not exceed 2^ADDR_W.
- BLOCK, 256: entries per DMA request. Power of two.

Ports:
- clk_in  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- ena  in  1  scheduler enable; gates write acceptance and new requests.
- wr_incr  in  1  producer wrote one entry at wr_addr this cycle.
- wr_addr  out  ADDR_W  current producer write address.
- wr_full  out  1  level == DEPTH.
- ovf_clr  in  1  clears the overflow flag.
- overflow  out  1  sticky; a write was dropped.
- dma_req  out  1  block request valid.
- dma_addr  out  ADDR_W  start address of the requested block.
- dma_ack  in  1  DMA engine accepted the request.
- dma_done  in  1  DMA engine finished the outstanding block.
- rd_addr  out  ADDR_W  oldest unconsumed entry.
- level  out  ADDR_W+1  entries written but not yet freed.

Behaviour:
- Reset (reset_n low, asynchronous) forces:
  - wr_addr, rd_addr, level = 0; overflow = 0; dma_req = 0; dma_addr = 0; FSM = IDLE.
  - Effect is immediate, including mid-handshake; the outstanding block is abandoned.
- Write path:
  - wr_incr && ena && !wr_full: wr_addr increments by 1; 0x3DFF wraps to 0.
  - wr_incr && ena && wr_full: write dropped; overflow set next cycle.
  - wr_incr while ena is low: ignored, no overflow.
- overflow: sticky. ovf_clr clears it; a simultaneous drop wins (flag stays 1).
- level update, registered:
  - +1 on an accepted write.
  - -BLOCK on dma_done in WAIT.
  - Both in the same cycle: level + 1 - BLOCK.
- wr_full is combinational from level.
- FSM, states IDLE / REQ / WAIT:
  - IDLE: when ena && level >= BLOCK, go to REQ. dma_req rises the next cycle with dma_addr = rd_addr.
  - REQ: dma_req = 1; dma_addr held stable. On dma_ack go to WAIT; dma_req drops the cycle after the ack. Deasserting ena in REQ does not withdraw the request.
  - WAIT: dma_req = 0. On dma_done: rd_addr += BLOCK modulo DEPTH, level -= BLOCK, go to IDLE.
- Minimum latency: first request one cycle after the level reaches BLOCK. Back-to-back: next request one cycle after done, if level >= BLOCK.
- Ignored handshake events: dma_ack outside REQ; dma_done outside WAIT; dma_ack and dma_done together in REQ (only the ack is taken).
- Only one block outstanding at a time.
- Blocks never straddle the wrap point, because DEPTH is a multiple of BLOCK.
- All arithmetic is unsigned. The level never underflows, because done only follows a request issued at level >= BLOCK.

Optional Feature:
- Macro: SONIC_CIRCBUF_STATS_EN.
- Defined: adds two outputs and their counters.
  - blk_cnt (32 bits): increments on each dma_done in WAIT; wraps.
  - drop_cnt (16 bits): increments on each dropped write; saturates at 0xFFFF.
  - Both reset to 0 on reset_n; drop_cnt also clears on ovf_clr.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then 255 writes with ena=1 → level=255, wr_addr=0x0FF, dma_req stays 0. 256th write → dma_req=1 next cycle, dma_addr=0x000.
- Request pending, dma_ack after 3 cycles → dma_req low the cycle after the ack. Then dma_done → rd_addr=0x100, level=0, FSM in IDLE.
- Fill to DEPTH=0x3E00 with no DMA, plus 2 more writes → wr_full=1, wr_addr=0x0000 (wrapped), overflow=1, level=0x3E00. With STATS_EN, drop_cnt=2.
- At level=0x3E00, wr_incr in the same cycle as dma_done → level=0x3D01 and the write is accepted. Then ovf_clr → overflow=0.
- Drive rd_addr to 0x3D00 and complete one block → rd_addr=0x0000; the next request's dma_addr=0x0000.
- Assert reset_n low while in REQ with dma_req=1 → dma_req=0 immediately (asynchronous). After release, level=0, all pointers 0, and dma_ack is ignored until a new request.
